// File: rtl/bus_rx_endpoint_if.sv
// Bus-facing and consumer-facing signals of the receive endpoint.
// The slave modport is the endpoint; the master modport is the bus/consumer side.
interface bus_rx_endpoint_if #(
    parameter int pckg_sz   = 16,
    parameter int deep_fifo = 8,
    parameter int cnt_w     = 8
);
    logic                         push;
    logic [pckg_sz-1:0]           D_push;
    logic                         out_valid;
    logic                         out_ready;
    logic [pckg_sz-1:0]           out_data;
    logic [$clog2(deep_fifo):0]   count;
    logic                         full;
    logic [cnt_w-1:0]             ovf_cnt;
    logic [cnt_w-1:0]             drop_cnt;

    modport slave (
        input  push, D_push, out_ready,
        output out_valid, out_data, count, full, ovf_cnt, drop_cnt
    );

    modport master (
        output push, D_push, out_ready,
        input  out_valid, out_data, count, full, ovf_cnt, drop_cnt
    );
endinterface

// File: rtl/bus_rx_endpoint.sv
// Receive endpoint: buffers arbiter pushes in a circular FIFO and presents them show-ahead.
// Optional destination-ID filtering is compiled in with BUS_RX_ID_FILTER_EN.
module bus_rx_endpoint #(
    parameter int         pckg_sz   = 16,
    parameter int         deep_fifo = 8,
    parameter logic [7:0] my_id     = 8'h00,
    parameter logic [7:0] bcast_id  = 8'hFF,
    parameter int         cnt_w     = 8
) (
    input  logic             clk,
    input  logic             reset,
    bus_rx_endpoint_if.slave bus
);
    localparam int AW = $clog2(deep_fifo);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(deep_fifo);

    logic [pckg_sz-1:0] mem [deep_fifo];

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [pckg_sz-1:0] head_q, head_d;
    logic [cnt_w-1:0]   ovf_q, ovf_d;

    logic eligible;
    logic xfer;
    logic is_full;
    logic store;
    logic lost;

`ifdef BUS_RX_ID_FILTER_EN
    logic [7:0]       dest_id;
    logic [cnt_w-1:0] drop_q, drop_d;
    logic             dropped;

    assign dest_id  = bus.D_push[pckg_sz-1 -: 8];
    assign eligible = (dest_id == my_id) || (dest_id == bcast_id);
    assign dropped  = bus.push && !eligible;

    always_comb begin
        drop_d = drop_q;
        if (dropped && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus.drop_cnt = drop_q;
`else
    logic unused_filter_ids;

    assign unused_filter_ids = ^{my_id, bcast_id};
    assign eligible          = 1'b1;
    assign bus.drop_cnt      = '0;
`endif

    always_comb begin
        xfer     = (count_q != '0) && bus.out_ready;
        is_full  = (count_q == DEPTH);
        // A full FIFO still accepts when the head leaves on the same edge.
        store    = bus.push && eligible && (!is_full || xfer);
        lost     = bus.push && eligible && is_full && !xfer;

        wr_ptr_d = store ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = xfer  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(store) - CW'(xfer);

        ovf_d = ovf_q;
        if (lost && (ovf_q != '1)) begin
            ovf_d = ovf_q + 1'b1;
        end

        // The new head may be the word being written this very edge.
        head_d = head_q;
        if (count_d != '0) begin
            if (store && (rd_ptr_d == wr_ptr_q)) begin
                head_d = bus.D_push;
            end else begin
                head_d = mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr_q] <= bus.D_push;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = head_q;
    assign bus.count     = count_q;
    assign bus.full      = (count_q == DEPTH);
    assign bus.ovf_cnt   = ovf_q;
endmodule

// File: tb/tb_bus_rx_endpoint.sv
// Directed self-checking bench for bus_rx_endpoint (deep_fifo=8, my_id=0).
// Filter-dependent expectations follow BUS_RX_ID_FILTER_EN.
module tb_bus_rx_endpoint;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    bus_rx_endpoint_if #(.pckg_sz(16), .deep_fifo(8), .cnt_w(8)) bus ();

    bus_rx_endpoint #(
        .pckg_sz(16), .deep_fifo(8), .my_id(8'h00), .bcast_id(8'hFF), .cnt_w(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] exp_q [$];
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.push = 1'b0;
        bus.D_push = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_ovf", 32'(bus.ovf_cnt), 32'd0);
        chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);

        // Single push, one-cycle latency, then drain
        bus.push = 1'b1; bus.D_push = 16'h0002;
        tick();
        bus.push = 1'b0;
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_data", 32'(bus.out_data), 32'h0002);
        chk("single_count", 32'(bus.count), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("single_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("single_drain_count", 32'(bus.count), 32'd0);

        // Three back-to-back pushes then ordered drain
        bus.push = 1'b1;
        bus.D_push = 16'h0003; tick();
        bus.D_push = 16'h0004; tick();
        bus.D_push = 16'h00FF; tick();
        bus.push = 1'b0;
        chk("three_count", 32'(bus.count), 32'd3);
        bus.out_ready = 1'b1;
        chk("three_d0", 32'(bus.out_data), 32'h0003); tick();
        chk("three_d1", 32'(bus.out_data), 32'h0004); tick();
        chk("three_d2", 32'(bus.out_data), 32'h00FF); tick();
        chk("three_empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Overfill: ten pushes into an 8-deep FIFO
        bus.push = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.D_push = 16'h0010 + 16'(i);
            tick();
        end
        bus.push = 1'b0;
        chk("ovf_count", 32'(bus.count), 32'd8);
        chk("ovf_full", 32'(bus.full), 32'd1);
        chk("ovf_cnt", 32'(bus.ovf_cnt), 32'd2);
        chk("ovf_head", 32'(bus.out_data), 32'h0010);

        // Push while full with a simultaneous transfer: stored, no overflow
        bus.push = 1'b1; bus.D_push = 16'h00AA; bus.out_ready = 1'b1;
        tick();
        bus.push = 1'b0;
        chk("fullx_count", 32'(bus.count), 32'd8);
        chk("fullx_ovf", 32'(bus.ovf_cnt), 32'd2);
        for (int i = 1; i < 8; i++) exp_q.push_back(16'h0010 + 16'(i));
        exp_q.push_back(16'h00AA);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fullx_d%0d", i), 32'(bus.out_data), 32'(exp_q[i]));
            tick();
        end
        exp_q.delete();
        chk("fullx_empty", 32'(bus.out_valid), 32'd0);
        chk("fullx_nfull", 32'(bus.full), 32'd0);
        bus.out_ready = 1'b0;

        // Destination-ID filtering
        bus.push = 1'b1;
        bus.D_push = 16'h0302; tick();
        bus.D_push = 16'h0002; tick();
        bus.D_push = 16'hFF05; tick();
        bus.push = 1'b0;
`ifdef BUS_RX_ID_FILTER_EN
        chk("filt_drop", 32'(bus.drop_cnt), 32'd1);
        chk("filt_count", 32'(bus.count), 32'd2);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'hFF05);
`else
        chk("filt_drop", 32'(bus.drop_cnt), 32'd0);
        chk("filt_count", 32'(bus.count), 32'd3);
        exp_q.push_back(16'h0302);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'hFF05);
`endif
        chk("filt_ovf", 32'(bus.ovf_cnt), 32'd2);
        bus.out_ready = 1'b1;
        foreach (exp_q[i]) begin
            chk($sformatf("filt_d%0d", i), 32'(bus.out_data), 32'(exp_q[i]));
            tick();
        end
        exp_q.delete();
        chk("filt_empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Fill to 5, then reset with a push in the reset cycle
        bus.push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.D_push = 16'h0040 + 16'(i);
            tick();
        end
        chk("prerst_count", 32'(bus.count), 32'd5);
        reset = 1'b1; bus.D_push = 16'h0050;
        tick();
        reset = 1'b0; bus.push = 1'b0;
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_ovf", 32'(bus.ovf_cnt), 32'd0);
        chk("midrst_drop", 32'(bus.drop_cnt), 32'd0);
        bus.push = 1'b1; bus.D_push = 16'h0060;
        tick();
        bus.push = 1'b0;
        chk("postrst_valid", 32'(bus.out_valid), 32'd1);
        chk("postrst_data", 32'(bus.out_data), 32'h0060);
        chk("postrst_count", 32'(bus.count), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("postrst_empty", 32'(bus.out_valid), 32'd0);

        // Push and out_ready together on an empty FIFO: stored, no transfer
        bus.push = 1'b1; bus.D_push = 16'h0070;
        tick();
        bus.push = 1'b0; bus.out_ready = 1'b0;
        chk("empty_pr_count", 32'(bus.count), 32'd1);
        chk("empty_pr_data", 32'(bus.out_data), 32'h0070);
        tick();
        chk("empty_pr_hold", 32'(bus.count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bus_rx_endpoint.md
Name: bus_rx_endpoint

Overview:
- Device-side receive endpoint of the bus generator/arbiter.
- Sinks the arbiter's push/D_push strobe into a local FIFO of deep_fifo words.
- Presents buffered packets to the local consumer over a valid/ready handshake.
- Acts as the reader counterpart of the per-device transmit FIFO, which drives pndng/pop/D_pop.
- Packet format: D_push[pckg_sz-1:pckg_sz-8] = destination ID; the remaining low bits are the payload.

Parameters:
- pckg_sz, 16, packet width in bits (minimum 9).
- deep_fifo, 8, FIFO depth in words (power of two, minimum 2).
- my_id, 0, this endpoint's 8-bit destination ID.
- bcast_id, 8'hFF, broadcast destination ID.
- cnt_w, 8, width of the saturating drop/overflow counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  one-cycle strobe from the arbiter: D_push is valid this cycle. There is no backpressure.
- D_push  in  pckg_sz  packet delivered by the bus.
- out_valid  out  1  head-of-FIFO packet available.
- out_ready  in  1  consumer accepts the head packet.
- out_data  out  pckg_sz  head-of-FIFO packet, unmodified from D_push.
- count  out  $clog2(deep_fifo)+1  current occupancy.
- full  out  1  count == deep_fifo.
- ovf_cnt  out  cnt_w  pushes lost because the FIFO was full; saturates at all-ones.
- drop_cnt  out  cnt_w  misrouted pushes discarded; saturates. Stays 0 when the optional feature is compiled out.

Behaviour:
- Reset: while reset = 1 at a clock edge, the following are cleared:
  - read/write pointers, count, ovf_cnt, drop_cnt;
  - out_valid = 0, full = 0, out_data = 0.
  - A push in the reset cycle is ignored and not counted.
  - Reset mid-stream discards all buffered packets.
- Storage: circular buffer. Pointers wrap modulo deep_fifo. Occupancy is tracked by a separate counter.
- Accept condition: push = 1 and the packet passes the ID filter (see Optional Feature).
- Write: the accepted packet is written at the write pointer on the same edge; the write pointer increments.
- Latency: a push into an empty FIFO at edge N gives out_valid = 1 with out_data = that packet after edge N, i.e. visible in cycle N+1. There is no bypass path in the push cycle.
- Read: out_valid = (count != 0). out_data is the word at the read pointer (show-ahead). A transfer occurs on any edge where out_valid && out_ready; the read pointer then increments. out_ready while out_valid = 0 has no effect.
- Count update per edge:
  - +1 on accept only;
  - -1 on transfer only;
  - unchanged on accept and transfer together.
- Full:
  - An accept with count == deep_fifo and no transfer on the same edge is lost and ovf_cnt increments.
  - An accept with count == deep_fifo and a transfer on the same edge is stored; count stays deep_fifo and ovf_cnt is unchanged.
- Empty: simultaneous push and out_ready on an empty FIFO stores the packet. No transfer occurs that edge (out_valid was 0).
- Counters saturate at 2^cnt_w-1 and never wrap.
- Ordering: strict FIFO. The payload is never altered.
- out_data while out_valid = 0 holds the last value. It is don't-care for checking.

Optional Feature:
- Macro: BUS_RX_ID_FILTER_EN.
- When defined:
  - A push whose destination ID is neither my_id nor bcast_id is discarded and drop_cnt increments (saturating).
  - A discarded push never touches the FIFO or ovf_cnt.
  - Broadcast packets are always eligible.
- When not defined:
  - Every push is eligible regardless of ID; filtering is the arbiter's job.
  - drop_cnt is tied to 0.

Test Plan:
- Reset, then push D_push=16'h0002 in one cycle -> next cycle out_valid=1, out_data=16'h0002, count=1. With out_ready=1, after one edge: out_valid=0, count=0.
- Push 16'h0003, 16'h0004, 16'h00FF on consecutive cycles with out_ready=0 -> count=3. Then out_ready=1 -> out_data presented as 0003, 0004, 00FF on successive cycles.
- deep_fifo=8: push 10 packets with out_ready=0 -> count=8, full=1, ovf_cnt=2; first 8 packets drained in order.
- Full FIFO: push 16'h00AA with out_ready=1 in the same cycle -> count stays 8, ovf_cnt unchanged, 16'h00AA is the last drained word.
- With BUS_RX_ID_FILTER_EN and my_id=2: push 16'h0302, 16'h0202, 16'hFF05 -> drop_cnt=1; out_data sequence is 0202, FF05. Without the macro, all three are stored and drop_cnt=0.
- Fill to 5 words, assert reset for one cycle with push=1 -> count=0, out_valid=0, ovf_cnt=0, drop_cnt=0. The next push appears alone after one cycle.
